// File: rtl/slow_vram_sched.sv
// Slow VRAM time-division scheduler: fixed 4-slot frame (sprite even, sprite odd, fix, CPU)
// driving a 32K x 16 SRAM and returning read words to each requester with a one-cycle strobe.
module slow_vram_sched #(
    parameter int SLOT_LEN  = 4,
    parameter bit CPU_STEAL = 1'b0
) (
    input  logic        CLK_24M,
    input  logic        nRESET,
    input  logic        SPR_EN,
    input  logic [14:0] SPR_ADDR,
    input  logic        FIX_EN,
    input  logic [14:0] FIX_ADDR,
    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [14:0] CPU_ADDR,
    input  logic [15:0] CPU_WDATA,
    output logic        CPU_BUSY,
    output logic        CPU_ACK,
    output logic [15:0] CPU_RDATA,
    output logic        SPR_VALID,
    output logic        SPR_ODD,
    output logic [15:0] SPR_DATA,
    output logic        FIX_VALID,
    output logic [15:0] FIX_DATA,
    output logic [14:0] SVRAM_ADDR,
    output logic [15:0] SVRAM_DATA_OUT,
    input  logic [15:0] SVRAM_DATA_IN,
    output logic        nBOE,
    output logic        nBWE,
    output logic [1:0]  VRAM_CYCLE
);

    typedef enum logic [1:0] {OWN_IDLE, OWN_SPR, OWN_FIX, OWN_CPU} owner_t;

    localparam logic [2:0] LAST   = 3'(SLOT_LEN - 1);
    localparam logic [2:0] WE_END = 3'(SLOT_LEN - 2);

    logic [2:0]  phase;
    logic [1:0]  slot;
    logic        run;
    owner_t      owner;
    logic        cpu_we_q;
    logic [14:0] cpu_addr_q;
    logic [15:0] cpu_wdata_q;

    logic        slot_end;
    logic        slot_start;
    logic [1:0]  next_slot;
    logic        cpu_pending;
    owner_t      next_owner;

    always_comb begin
        slot_end   = run && (phase == LAST);
        slot_start = !run || slot_end;
        next_slot  = run ? 2'(slot + 2'd1) : 2'd0;
        // A CPU access completing on this edge must not be serviced again by the slot starting now.
        cpu_pending = CPU_BUSY && !(slot_end && owner == OWN_CPU);
        next_owner = OWN_IDLE;
        case (next_slot)
            2'd0, 2'd1: if (SPR_EN) next_owner = OWN_SPR;
            2'd2: begin
                if (FIX_EN)                      next_owner = OWN_FIX;
                else if (CPU_STEAL && cpu_pending) next_owner = OWN_CPU;
            end
            default: if (cpu_pending) next_owner = OWN_CPU;
        endcase
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            phase          <= '0;
            slot           <= '0;
            run            <= 1'b0;
            owner          <= OWN_IDLE;
            cpu_we_q       <= 1'b0;
            cpu_addr_q     <= '0;
            cpu_wdata_q    <= '0;
            CPU_BUSY       <= 1'b0;
            CPU_ACK        <= 1'b0;
            CPU_RDATA      <= '0;
            SPR_VALID      <= 1'b0;
            SPR_ODD        <= 1'b0;
            SPR_DATA       <= '0;
            FIX_VALID      <= 1'b0;
            FIX_DATA       <= '0;
            SVRAM_ADDR     <= '0;
            SVRAM_DATA_OUT <= '0;
            nBOE           <= 1'b1;
            nBWE           <= 1'b1;
            VRAM_CYCLE     <= 2'b11;
        end else begin
            SPR_VALID <= 1'b0;
            FIX_VALID <= 1'b0;
            CPU_ACK   <= 1'b0;

            if (!CPU_BUSY && CPU_REQ) begin
                cpu_we_q    <= CPU_WE;
                cpu_addr_q  <= CPU_ADDR;
                cpu_wdata_q <= CPU_WDATA;
                CPU_BUSY    <= 1'b1;
            end

            if (slot_end) begin
                case (owner)
                    OWN_SPR: begin
                        SPR_DATA  <= SVRAM_DATA_IN;
                        SPR_ODD   <= slot[0];
                        SPR_VALID <= 1'b1;
                    end
                    OWN_FIX: begin
                        FIX_DATA  <= SVRAM_DATA_IN;
                        FIX_VALID <= 1'b1;
                    end
                    OWN_CPU: begin
                        if (!cpu_we_q) CPU_RDATA <= SVRAM_DATA_IN;
                        CPU_ACK  <= 1'b1;
                        CPU_BUSY <= 1'b0;
                    end
                    default: ;
                endcase
            end

            if (slot_start) begin
                owner <= next_owner;
                case (next_owner)
                    OWN_SPR: begin
                        SVRAM_ADDR <= {SPR_ADDR[14:1], next_slot[0]};
                        nBOE       <= 1'b0;
                        VRAM_CYCLE <= 2'b10;
                    end
                    OWN_FIX: begin
                        SVRAM_ADDR <= FIX_ADDR;
                        nBOE       <= 1'b0;
                        VRAM_CYCLE <= 2'b00;
                    end
                    OWN_CPU: begin
                        SVRAM_ADDR <= cpu_addr_q;
                        nBOE       <= cpu_we_q;
                        VRAM_CYCLE <= 2'b01;
                        if (cpu_we_q) SVRAM_DATA_OUT <= cpu_wdata_q;
                    end
                    default: begin
                        nBOE       <= 1'b1;
                        VRAM_CYCLE <= 2'b11;
                    end
                endcase
            end

            // Write strobe spans phases 1..SLOT_LEN-2 so the address is stable a cycle either side.
            if (run && phase == 3'd0 && owner == OWN_CPU && cpu_we_q)
                nBWE <= 1'b0;
            else if (phase == WE_END)
                nBWE <= 1'b1;

            if (!run) begin
                run   <= 1'b1;
                phase <= '0;
                slot  <= '0;
            end else if (phase == LAST) begin
                phase <= '0;
                slot  <= 2'(slot + 2'd1);
            end else begin
                phase <= 3'(phase + 3'd1);
            end
        end
    end

endmodule

// File: tb/tb_slow_vram_sched.sv
// Scoreboard bench for slow_vram_sched: directed CPU/video traffic against a behavioural SRAM,
// plus a second instance without CPU stealing to compare fix-slot ownership.
module tb_slow_vram_sched;

    logic        clk;
    logic        rst_n;
    logic        SPR_EN, FIX_EN, CPU_REQ, CPU_WE;
    logic [14:0] SPR_ADDR, FIX_ADDR, CPU_ADDR;
    logic [15:0] CPU_WDATA;

    logic        CPU_BUSY, CPU_ACK, SPR_VALID, SPR_ODD, FIX_VALID, nBOE, nBWE;
    logic [15:0] CPU_RDATA, SPR_DATA, FIX_DATA, sv_dout, sv_din;
    logic [14:0] sv_addr;
    logic [1:0]  VRAM_CYCLE;

    logic        ns_busy, ns_ack, ns_sv, ns_so, ns_fv, ns_nboe, ns_nbwe;
    logic [15:0] ns_rdata, ns_sdata, ns_fdata, ns_dout, ns_din;
    logic [14:0] ns_addr;
    logic [1:0]  ns_vc;

    logic [15:0] mem [0:32767];
    int          cyc;
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct {
        int          kind;   // 0 sprite, 1 fix, 2 cpu
        logic        odd;
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t q[$];

    slow_vram_sched #(.SLOT_LEN(4), .CPU_STEAL(1'b1)) dut (
        .CLK_24M(clk), .nRESET(rst_n),
        .SPR_EN(SPR_EN), .SPR_ADDR(SPR_ADDR), .FIX_EN(FIX_EN), .FIX_ADDR(FIX_ADDR),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_BUSY(CPU_BUSY), .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA),
        .SPR_VALID(SPR_VALID), .SPR_ODD(SPR_ODD), .SPR_DATA(SPR_DATA),
        .FIX_VALID(FIX_VALID), .FIX_DATA(FIX_DATA),
        .SVRAM_ADDR(sv_addr), .SVRAM_DATA_OUT(sv_dout), .SVRAM_DATA_IN(sv_din),
        .nBOE(nBOE), .nBWE(nBWE), .VRAM_CYCLE(VRAM_CYCLE)
    );

    slow_vram_sched #(.SLOT_LEN(4), .CPU_STEAL(1'b0)) dut_ns (
        .CLK_24M(clk), .nRESET(rst_n),
        .SPR_EN(SPR_EN), .SPR_ADDR(SPR_ADDR), .FIX_EN(FIX_EN), .FIX_ADDR(FIX_ADDR),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_BUSY(ns_busy), .CPU_ACK(ns_ack), .CPU_RDATA(ns_rdata),
        .SPR_VALID(ns_sv), .SPR_ODD(ns_so), .SPR_DATA(ns_sdata),
        .FIX_VALID(ns_fv), .FIX_DATA(ns_fdata),
        .SVRAM_ADDR(ns_addr), .SVRAM_DATA_OUT(ns_dout), .SVRAM_DATA_IN(ns_din),
        .nBOE(ns_nboe), .nBWE(ns_nbwe), .VRAM_CYCLE(ns_vc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: asynchronous read, write on rising edge while nBWE is low.
    assign sv_din = mem[sv_addr];
    assign ns_din = ns_addr ^ 16'h5A5A;
    always @(posedge clk) if (!nBWE) mem[sv_addr] <= sv_dout;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= -1;
        else        cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic odd, input logic [15:0] data, input int c);
        exp_t e;
        e.kind = kind; e.odd = odd; e.data = data; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic check_pulse(input int kind, input logic odd, input logic [15:0] data);
        exp_t e;
        if (q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_pulse kind %0d @cyc %0d: got data %h expected no pulse", kind, cyc, data);
        end else begin
            e = q.pop_front();
            chk("pulse_kind", kind, e.kind);
            chk("pulse_cycle", cyc, e.cyc);
            chk("pulse_data", data, e.data);
            if (kind == 0) chk("spr_odd", odd, e.odd);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_addr"}, sv_addr, 15'h0);
        chk({tag, "_dout"}, sv_dout, 16'h0);
        chk({tag, "_nboe"}, nBOE, 1'b1);
        chk({tag, "_nbwe"}, nBWE, 1'b1);
        chk({tag, "_vc"}, VRAM_CYCLE, 2'b11);
        chk({tag, "_busy"}, CPU_BUSY, 1'b0);
        chk({tag, "_ack"}, CPU_ACK, 1'b0);
        chk({tag, "_rdata"}, CPU_RDATA, 16'h0);
        chk({tag, "_sv"}, SPR_VALID, 1'b0);
        chk({tag, "_sdata"}, SPR_DATA, 16'h0);
        chk({tag, "_fv"}, FIX_VALID, 1'b0);
        chk({tag, "_fdata"}, FIX_DATA, 16'h0);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: every strobe must match the next queued expectation.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (SPR_VALID) check_pulse(0, SPR_ODD, SPR_DATA);
            if (FIX_VALID) check_pulse(1, 1'b0, FIX_DATA);
            if (CPU_ACK) begin
                check_pulse(2, 1'b0, CPU_RDATA);
                chk("busy_low_on_ack", CPU_BUSY, 1'b0);
            end
        end
    end

    initial begin
        for (int unsigned a = 0; a < 32768; a++) mem[a] = 16'(a) ^ 16'h5A5A;
        rst_n = 1'b0;
        SPR_EN = 1'b0; FIX_EN = 1'b0; CPU_REQ = 1'b0; CPU_WE = 1'b0;
        SPR_ADDR = '0; FIX_ADDR = '0; CPU_ADDR = '0; CPU_WDATA = '0;
        repeat (3) @(negedge clk);
        check_reset("init");

        // Video slots plus a CPU read issued at cycle 2.
        SPR_EN = 1'b1; FIX_EN = 1'b1; SPR_ADDR = 15'h1235; FIX_ADDR = 15'h7000;
        push(0, 1'b0, 16'h486E, 4);
        push(0, 1'b1, 16'h486F, 8);
        push(1, 1'b0, 16'h2A5A, 12);
        push(2, 1'b0, 16'h20E6, 16);
        rst_n = 1'b1;
        wait_cyc(0);
        chk("spr_even_addr", sv_addr, 15'h1234);
        chk("spr_vc", VRAM_CYCLE, 2'b10);
        chk("spr_nboe", nBOE, 1'b0);
        wait_cyc(2);
        chk("busy_before_req", CPU_BUSY, 1'b0);
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 15'h7ABC;
        wait_cyc(3);
        chk("busy_after_req", CPU_BUSY, 1'b1);
        CPU_REQ = 1'b0;
        wait_cyc(4);
        chk("spr_odd_addr", sv_addr, 15'h1235);
        wait_cyc(8);
        chk("fix_addr", sv_addr, 15'h7000);
        chk("fix_vc", VRAM_CYCLE, 2'b00);
        wait_cyc(9);
        SPR_EN = 1'b0; FIX_EN = 1'b0;
        for (int c = 12; c <= 15; c++) begin
            wait_cyc(c);
            chk("cpu_rd_vc", VRAM_CYCLE, 2'b01);
        end
        chk("cpu_rd_addr", sv_addr, 15'h7ABC);
        wait_cyc(16);
        chk("spr_disabled_vc", VRAM_CYCLE, 2'b11);
        chk("spr_disabled_nboe", nBOE, 1'b1);

        // CPU write in slot 3 of frame 1; ACK leaves CPU_RDATA at the previous read.
        wait_cyc(24);
        push(2, 1'b0, 16'h20E6, 32);
        CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 15'h0100; CPU_WDATA = 16'hBEEF;
        wait_cyc(25);
        CPU_REQ = 1'b0;
        chk("wr_busy", CPU_BUSY, 1'b1);
        for (int c = 28; c <= 31; c++) begin
            wait_cyc(c);
            chk("wr_nbwe", nBWE, (c == 29 || c == 30) ? 1'b0 : 1'b1);
            chk("wr_nboe", nBOE, 1'b1);
            chk("wr_vc", VRAM_CYCLE, 2'b01);
            chk("wr_dout", sv_dout, 16'hBEEF);
            chk("wr_addr", sv_addr, 15'h0100);
        end

        // Stolen fix slot reads back the written word; requests while busy are ignored.
        wait_cyc(33);
        push(2, 1'b0, 16'hBEEF, 44);
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 15'h0100;
        wait_cyc(34);
        CPU_REQ = 1'b0;
        wait_cyc(36);
        CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 15'h0400; CPU_WDATA = 16'hDEAD;
        wait_cyc(39);
        CPU_REQ = 1'b0;
        wait_cyc(40);
        chk("steal_vc", VRAM_CYCLE, 2'b01);
        chk("steal_addr", sv_addr, 15'h0100);
        chk("nosteal_fix_vc", ns_vc, 2'b11);
        wait_cyc(44);
        chk("after_steal_cpu_slot_vc", VRAM_CYCLE, 2'b11);
        chk("nosteal_cpu_slot_vc", ns_vc, 2'b01);
        push(2, 1'b0, 16'h595A, 60);
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 15'h0300;
        wait_cyc(45);
        CPU_REQ = 1'b0;
        chk("req_on_ack_captured", CPU_BUSY, 1'b1);
        wait_cyc(56);
        chk("next_frame_vc", VRAM_CYCLE, 2'b01);
        chk("next_frame_addr", sv_addr, 15'h0300);

        // Asynchronous reset in the middle of a write strobe.
        wait_cyc(61);
        CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 15'h0500; CPU_WDATA = 16'h2222;
        wait_cyc(62);
        CPU_REQ = 1'b0;
        wait_cyc(72);
        chk("mid_wr_vc", VRAM_CYCLE, 2'b01);
        wait_cyc(73);
        chk("mid_wr_nbwe_low", nBWE, 1'b0);
        #1 rst_n = 1'b0;
        #1 check_reset("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(40);
        chk("busy_after_reset", CPU_BUSY, 1'b0);
        chk("mem_0500_untouched", mem[15'h0500], 16'h0500 ^ 16'h5A5A);
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/slow_vram_sched.md
Name: slow_vram_sched

Overview:
Time-division scheduler for the 32K x 16 slow VRAM (fix map, sprite map, CPU window). Runs a fixed 4-slot frame (sprite even, sprite odd, fix, CPU) on CLK_24M, drives the SRAM address/data/strobes, and returns read words to each requester with a one-cycle valid strobe. The CPU port is a request/acknowledge handshake; video requesters are enable-gated with a fixed slot position.

Parameters:
SLOT_LEN, 4, CLK_24M cycles per slot (legal range 3..8); frame = 4*SLOT_LEN cycles.
CPU_STEAL, 0, if 1, an idle fix slot (FIX_EN=0) is given to a pending CPU request.

Ports:
CLK_24M  in  1  master clock, all logic rising-edge
nRESET  in  1  asynchronous active-low reset
SPR_EN  in  1  enable sprite-map slots 0/1 (sampled at slot start)
SPR_ADDR  in  15  sprite map word address; bit 0 ignored
FIX_EN  in  1  enable fix slot 2 (sampled at slot start)
FIX_ADDR  in  15  fix map word address
CPU_REQ  in  1  CPU access request (level, sampled while CPU_BUSY=0)
CPU_WE  in  1  1 = write, 0 = read; captured with request
CPU_ADDR  in  15  CPU word address; captured with request
CPU_WDATA  in  16  CPU write data; captured with request
CPU_BUSY  out  1  request held, not yet serviced
CPU_ACK  out  1  one-cycle pulse: access complete
CPU_RDATA  out  16  read data, valid when CPU_ACK=1, held until next read
SPR_VALID  out  1  one-cycle pulse per sprite word
SPR_ODD  out  1  0 = even word, 1 = odd word, qualifies SPR_VALID
SPR_DATA  out  16  sprite map word, held
FIX_VALID  out  1  one-cycle pulse per fix word
FIX_DATA  out  16  fix map word, held
SVRAM_ADDR  out  15  SRAM address
SVRAM_DATA_OUT  out  16  SRAM write data
SVRAM_DATA_IN  in  16  SRAM read data
nBOE  out  1  SRAM output enable, active low
nBWE  out  1  SRAM write enable, active low
VRAM_CYCLE  out  2  slot hint: 10 sprite, 01 CPU, 00 fix, 11 idle

Behaviour:
- Reset (async, nRESET=0): PHASE=0, SLOT=0, nBOE=1, nBWE=1, SVRAM_ADDR=0, SVRAM_DATA_OUT=0, VRAM_CYCLE=11, all *_DATA=0, all valids/ACK=0, CPU_BUSY=0. First slot starts on first edge after release.
- PHASE counts 0..SLOT_LEN-1; on wrap SLOT increments mod 4 (0 spr-even, 1 spr-odd, 2 fix, 3 CPU).
- Slot start (edge entering PHASE=0): owner decided and registered: SVRAM_ADDR, VRAM_CYCLE, nBOE, SVRAM_DATA_OUT. Owner fixed for whole slot; mid-slot changes of EN/ADDR ignored.
- Sprite slots: addr {SPR_ADDR[14:1],SLOT[0]}; nBOE=0. Fix slot: FIX_ADDR; nBOE=0. Disabled video slot: idle, nBOE=1, address held, VRAM_CYCLE=11, no valid.
- CPU slot: serviced only if CPU_BUSY=1 at slot start; else idle. CPU_STEAL=1: fix slot with FIX_EN=0 and CPU_BUSY=1 becomes CPU slot (VRAM_CYCLE=01).
- Read slot: SVRAM_DATA_IN captured on edge leaving PHASE=SLOT_LEN-1; corresponding VALID/ACK high the following cycle (one cycle), data register updated same edge.
- Write slot: nBOE=1 entire slot; SVRAM_DATA_OUT=captured CPU_WDATA entire slot; nBWE=0 exactly for PHASE 1..SLOT_LEN-2 (registered, glitch-free); address stable one cycle either side of nBWE low. CPU_ACK pulses as for read; CPU_RDATA unchanged.
- CPU handshake: CPU_REQ=1 with CPU_BUSY=0 captures WE/ADDR/WDATA; CPU_BUSY=1 next cycle. Requests while busy ignored. CPU_BUSY falls in the same cycle CPU_ACK is high; new request may be captured that cycle. Worst-case latency accept→ACK = 5*SLOT_LEN+1 cycles (4*SLOT_LEN+1 frame, +SLOT_LEN wait).
- Request captured on the same edge as CPU-slot start is NOT serviced in that slot (BUSY not yet 1).
- nRESET mid-write forces nBWE=1 immediately (async); pending request discarded.

Test Plan:
- Reset then SPR_EN=FIX_EN=1, SPR_ADDR=0x1235, FIX_ADDR=0x7000, SLOT_LEN=4 -> SVRAM_ADDR 0x1234,0x1235,0x7000 at cycles 0,4,8; SPR_VALID at cycles 4 (ODD=0) and 8 (ODD=1), FIX_VALID at 12, data match SRAM model.
- CPU read 0x7ABC requested with BUSY=0 at cycle 2 -> BUSY=1 cycle 3, VRAM_CYCLE=01 cycles 12-15, CPU_ACK cycle 16 with model data, BUSY=0 cycle 16.
- CPU write 0x0100=0xBEEF -> nBWE low exactly cycles 13-14 of CPU slot, nBOE=1, model word updated, CPU_ACK once.
- FIX_EN=0, CPU_STEAL=1, request pending at fix-slot start -> access in slot 2 with VRAM_CYCLE=01; CPU_STEAL=0 -> slot 2 idle (11), serviced in slot 3.
- Second CPU_REQ held while BUSY -> ignored; re-asserted on ACK cycle -> captured, serviced next frame.
- nRESET asserted at PHASE 1 of write slot -> nBWE=1 and all outputs at reset values without clock edge; no ACK after release.
